// File: rtl/proc_mem_arbiter_if.sv
// proc_mem_arbiter_if: request/response handshakes for two requesters plus the memory port.
// slave is the arbiter side, master is the requester/memory environment side.
interface proc_mem_arbiter_if #(parameter int p_addr_nbits = 32);
    logic                    req0_val, req0_rdy, req0_type;
    logic [p_addr_nbits-1:0] req0_addr;
    logic [31:0]             req0_wdata;
    logic                    resp0_val, resp0_rdy;
    logic [31:0]             resp0_data;
    logic                    req1_val, req1_rdy, req1_type;
    logic [p_addr_nbits-1:0] req1_addr;
    logic [31:0]             req1_wdata;
    logic                    resp1_val, resp1_rdy;
    logic [31:0]             resp1_data;
    logic [p_addr_nbits-1:0] mem_addr;
    logic                    mem_wen;
    logic [31:0]             mem_wdata, mem_rdata;
    modport slave (
        input  req0_val, req0_type, req0_addr, req0_wdata, resp0_rdy,
        input  req1_val, req1_type, req1_addr, req1_wdata, resp1_rdy, mem_rdata,
        output req0_rdy, resp0_val, resp0_data, req1_rdy, resp1_val, resp1_data,
        output mem_addr, mem_wen, mem_wdata
    );
    modport master (
        output req0_val, req0_type, req0_addr, req0_wdata, resp0_rdy,
        output req1_val, req1_type, req1_addr, req1_wdata, resp1_rdy, mem_rdata,
        input  req0_rdy, resp0_val, resp0_data, req1_rdy, resp1_val, resp1_data,
        input  mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/proc_mem_arbiter.sv
// proc_mem_arbiter: arbitrates fetch (port 0) and data (port 1) requests onto one memory port.
// Fixed priority to port 0 by default; define PROC_MEM_ARBITER_RR_EN for round-robin.
module proc_mem_arbiter #(parameter int p_addr_nbits = 32) (
    input logic              clk,
    input logic              rst,
    proc_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2;
    logic [1:0]              state;
    logic                    lat_port, lat_type, win, idle, accept, sel_rdy;
    logic [p_addr_nbits-1:0] lat_addr;
    logic [31:0]             lat_wdata, resp_reg, resp_data;
`ifdef PROC_MEM_ARBITER_RR_EN
    logic ptr;
    // ptr names the port favoured on a conflict; a lone requester always wins
    assign win = (bus.req0_val & bus.req1_val) ? ptr : bus.req1_val;
`else
    assign win = !bus.req0_val;
`endif
    assign idle           = state == IDLE && !rst;
    assign accept         = idle && (bus.req0_val || bus.req1_val);
    assign bus.req0_rdy   = idle && bus.req0_val && !win;
    assign bus.req1_rdy   = idle && bus.req1_val && win;
    assign resp_data      = state == ACCESS ? (lat_type ? 32'd0 : bus.mem_rdata) : resp_reg;
    assign bus.resp0_val  = !rst && state != IDLE && !lat_port;
    assign bus.resp1_val  = !rst && state != IDLE && lat_port;
    assign bus.resp0_data = resp_data;
    assign bus.resp1_data = resp_data;
    assign sel_rdy        = lat_port ? bus.resp1_rdy : bus.resp0_rdy;
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_wdata  = lat_wdata;
    // only ACCESS writes, so a stalled or reset transaction never repeats its write
    assign bus.mem_wen    = !rst && state == ACCESS && lat_type;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_port  <= 1'b0;
            lat_type  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            resp_reg  <= '0;
`ifdef PROC_MEM_ARBITER_RR_EN
            ptr       <= 1'b0;
`endif
        end else if (accept) begin
            state     <= ACCESS;
            lat_port  <= win;
            lat_type  <= win ? bus.req1_type : bus.req0_type;
            lat_addr  <= win ? bus.req1_addr : bus.req0_addr;
            lat_wdata <= win ? bus.req1_wdata : bus.req0_wdata;
`ifdef PROC_MEM_ARBITER_RR_EN
            ptr       <= !win;
`endif
        end else if (state == ACCESS) begin
            state     <= sel_rdy ? IDLE : WAIT;
            resp_reg  <= resp_data;
        end else if (state == WAIT && sel_rdy) begin
            state     <= IDLE;
        end
    end
endmodule

// File: tb/tb_proc_mem_arbiter.sv
// tb_proc_mem_arbiter: randomized transactions checked against a word-array memory model
// and a "grant the port not granted last" arbitration model.
module tb_proc_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_mem_arbiter_if #(.p_addr_nbits(32)) bus();
    proc_mem_arbiter #(.p_addr_nbits(32)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef PROC_MEM_ARBITER_RR_EN
    localparam bit rr = 1'b1;
`else
    localparam bit rr = 1'b0;
`endif

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_a = 8'd0;
    logic [31:0] pre_d = 32'd0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          last_g = 1'b1;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk)
        if (pre_en) mem[pre_a] <= pre_d;
        else if (bus.mem_wen) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

    task automatic set_req(input bit p, input bit v, input bit t, input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            bus.req1_val = v; bus.req1_type = t; bus.req1_addr = a; bus.req1_wdata = wd;
        end else begin
            bus.req0_val = v; bus.req0_type = t; bus.req0_addr = a; bus.req0_wdata = wd;
        end
    endtask

    task automatic quiet();
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        bus.resp0_rdy = 1'b0;
        bus.resp1_rdy = 1'b0;
    endtask

    // Drives one transaction on port p and reports what was observed.
    task automatic issue(input bit p, input bit t, input logic [31:0] a, input logic [31:0] wd, input int stall,
                         output int lat, output logic [31:0] data, output int vcyc, output int wcyc, output bit bad);
        bit acc, done, v;
        logic [31:0] first;
        lat = 0; vcyc = 0; wcyc = 0; bad = 1'b0; data = '0; first = '0; acc = 1'b0; done = 1'b0;
        set_req(p, 1'b1, t, a, wd);
        set_req(!p, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (p ? bus.req1_rdy : bus.req0_rdy) acc = 1'b1; else lat++;
            if (p ? bus.req0_rdy : bus.req1_rdy) bad = 1'b1;
            wcyc += int'(bus.mem_wen);
            @(posedge clk); #1;
        end
        if (acc) last_g = p;
        for (int k = 0; k < 20 && acc && !done; k++) begin
            set_req(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            set_req(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (p) begin bus.resp1_rdy = (k >= stall); bus.resp0_rdy = 1'b1; end
            else   begin bus.resp0_rdy = (k >= stall); bus.resp1_rdy = 1'b1; end
            @(negedge clk);
            v = p ? bus.resp1_val : bus.resp0_val;
            if (bus.req0_rdy || bus.req1_rdy || (p ? bus.resp0_val : bus.resp1_val) || (k == 0 && !v)) bad = 1'b1;
            wcyc += int'(bus.mem_wen);
            if (v) begin
                data = p ? bus.resp1_data : bus.resp0_data;
                if (vcyc == 0) first = data; else if (data !== first) bad = 1'b1;
                vcyc++;
                if (p ? bus.resp1_rdy : bus.resp0_rdy) done = 1'b1;
            end
            @(posedge clk); #1;
        end
        quiet();
        if (!done) bad = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        quiet();
        bus.req0_type = 1'b0; bus.req1_type = 1'b0;
        rst = 1'b1;
        last_g = 1'b1;
        bus.req0_val = 1'b1; bus.req1_val = 1'b1;
        for (int i = 0; i < 256; i++) begin
            d = (i == 16) ? 32'hDEADBEEF : (i == 8) ? 32'h0808CAFE : {8'(i), 24'h5A5A00} ^ 32'h00C3_0000;
            pre_en = 1'b1; pre_a = 8'(i); pre_d = d; ref_mem[i] = d;
            @(posedge clk); #1;
        end
        pre_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val, bus.mem_wen} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy0/rdy1/rv0/rv1/wen got %b want 00000",
                     {bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val, bus.mem_wen});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        quiet();
        @(negedge clk);
        n_cmp++;
        if ({bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val, bus.mem_wen} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_outputs: rdy0/rdy1/rv0/rv1/wen got %b want 00000",
                     {bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val, bus.mem_wen});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_port1();
        int lat, vc, wc; logic [31:0] d; bit bad;
        issue(1'b1, 1'b0, 32'h10, 32'h0, 0, lat, d, vc, wc, bad);
        n_cmp++;
        if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL read1_data: got %h want deadbeef", d); end
        n_cmp++;
        if ({lat, vc, wc, 32'(bad)} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
            n_err++; $display("FAIL read1_timing: lat=%0d vcyc=%0d wen=%0d bad=%0d want 0 1 0 0", lat, vc, wc, bad);
        end
    endtask

    task automatic test_write_read();
        int lat, vc, wc; logic [31:0] d; bit bad;
        issue(1'b0, 1'b1, 32'h4, 32'h12345678, 0, lat, d, vc, wc, bad);
        ref_mem[4] = 32'h12345678;
        n_cmp++;
        if ({d, 32'(wc), 32'(bad)} !== {32'd0, 32'd1, 32'd0}) begin
            n_err++; $display("FAIL write0_resp: data=%h wen=%0d bad=%0d want 0 1 0", d, wc, bad);
        end
        issue(1'b0, 1'b0, 32'h4, 32'h0, 0, lat, d, vc, wc, bad);
        n_cmp++;
        if (d !== 32'h12345678) begin n_err++; $display("FAIL readback0: got %h want 12345678", d); end
        n_cmp++;
        if (mem[4] !== 32'h12345678) begin n_err++; $display("FAIL mem4: got %h want 12345678", mem[4]); end
    endtask

    task automatic test_stall();
        int lat, vc, wc; logic [31:0] d; bit bad;
        issue(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 3, lat, d, vc, wc, bad);
        ref_mem[8'h30] = 32'hA5A5A5A5;
        n_cmp++;
        if (vc !== 4) begin n_err++; $display("FAIL stall_val_cycles: got %0d want 4", vc); end
        n_cmp++;
        if (wc !== 1) begin n_err++; $display("FAIL stall_wen_cycles: got %0d want 1", wc); end
        n_cmp++;
        if ({d, 32'(bad)} !== {32'd0, 32'd0}) begin
            n_err++; $display("FAIL stall_resp: data=%h bad=%0d want 0 0", d, bad);
        end
        n_cmp++;
        if (mem[8'h30] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL stall_mem: got %h want a5a5a5a5", mem[8'h30]); end
    endtask

    task automatic test_conflict();
        int n, prev;
        bit exp, gap_bad;
        n = 0; prev = -2; gap_bad = 1'b0;
        bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (bus.req0_rdy || bus.req1_rdy) begin
                exp = rr ? !last_g : 1'b0;
                n_cmp++;
                if (bus.req1_rdy !== exp || bus.req0_rdy === bus.req1_rdy) begin
                    n_err++;
                    $display("FAIL conflict_grant %0d: rdy0=%b rdy1=%b want port %0d", n, bus.req0_rdy, bus.req1_rdy, exp);
                end
                if (n > 0 && c - prev != 2) gap_bad = 1'b1;
                last_g = bus.req1_rdy;
                prev = c; n++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({32'(n), 32'(gap_bad)} !== {32'd6, 32'd0}) begin
            n_err++; $display("FAIL conflict_throughput: accepts=%0d gap_bad=%0d want 6 0", n, gap_bad);
        end
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        quiet();
    endtask

    task automatic test_reset_wait();
        int lat, vc, wc; logic [31:0] d; bit bad, acc;
        acc = 1'b0; wc = 0;
        set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'hC0FFEE11);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.req0_rdy;
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); wc += int'(bus.mem_wen);
        @(posedge clk); #1;
        @(negedge clk); wc += int'(bus.mem_wen);
        n_cmp++;
        if ({acc, bus.resp0_val} !== 2'b11) begin
            n_err++; $display("FAIL rw_wait: accepted=%b resp0_val=%b want 1 1", acc, bus.resp0_val);
        end
        @(posedge clk); #1;
        rst = 1'b1; last_g = 1'b1;
        @(negedge clk); wc += int'(bus.mem_wen);
        n_cmp++;
        if ({bus.resp0_val, bus.resp1_val, bus.req0_rdy, bus.req1_rdy} !== 4'b0) begin
            n_err++; $display("FAIL rw_in_reset: rv0/rv1/rdy0/rdy1 got %b want 0000",
                              {bus.resp0_val, bus.resp1_val, bus.req0_rdy, bus.req1_rdy});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.resp0_rdy = 1'b1;
        @(negedge clk); wc += int'(bus.mem_wen);
        n_cmp++;
        if ({bus.resp0_val, 32'(wc)} !== {1'b0, 32'd1}) begin
            n_err++; $display("FAIL rw_after_reset: resp0_val=%b wen_cycles=%0d want 0 1", bus.resp0_val, wc);
        end
        @(posedge clk); #1;
        ref_mem[8'h20] = 32'hC0FFEE11;
        n_cmp++;
        if (mem[8'h20] !== 32'hC0FFEE11) begin n_err++; $display("FAIL rw_mem: got %h want c0ffee11", mem[8'h20]); end
        quiet();
        issue(1'b0, 1'b0, 32'h8, 32'h0, 0, lat, d, vc, wc, bad);
        n_cmp++;
        if ({d, 32'(bad)} !== {32'h0808CAFE, 32'd0}) begin
            n_err++; $display("FAIL rw_read8: data=%h bad=%0d want 0808cafe 0", d, bad);
        end
    endtask

    task automatic test_random();
        int lat, vc, wc, st; logic [31:0] d, a, wd, exp; bit bad, p, t;
        for (int n = 0; n < 40; n++) begin
            p = 1'($urandom_range(0, 1)); t = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 63)); wd = $urandom; st = $urandom_range(0, 2);
            exp = t ? 32'd0 : ref_mem[a[7:0]];
            if (t) ref_mem[a[7:0]] = wd;
            issue(p, t, a, wd, st, lat, d, vc, wc, bad);
            n_cmp++;
            if (d !== exp) begin
                n_err++; $display("FAIL rand_data %0d: port=%0d type=%0d addr=%0h got %h want %h", n, p, t, a, d, exp);
            end
            n_cmp++;
            if ({lat, vc, wc, 32'(bad)} !== {32'd0, st + 1, 32'(t), 32'd0}) begin
                n_err++; $display("FAIL rand_timing %0d: lat=%0d vcyc=%0d wen=%0d bad=%0d want 0 %0d %0d 0",
                                  n, lat, vc, wc, bad, st + 1, t);
            end
        end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (mem[i] !== ref_mem[i]) begin n_err++; $display("FAIL rand_mem[%0d]: got %h want %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_read_port1();
        test_write_read();
        test_stall();
        test_conflict();
        test_reset_wait();
        test_random();
        test_conflict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
